bcd_timer: RTL

BCD_TIMER -- requirements
Module: bcd_timer

---
 rtl/bcd_timer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/bcd_timer.sv
// rtl/bcd_timer.sv - MM:SS BCD up/down timer with adjust, lap freeze and multiplexed 4-digit display.
module bcd_timer #(
  parameter int TICK_DIV  = 100000000,
  parameter int ADJ_DIV   = 50000000,
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000,
  parameter int MIN_MAX   = 99
) (
  input  logic       in_clock,
  input  logic       in_reset_n,
  input  logic       in_start_stop,
  input  logic       in_clear,
  input  logic       in_lap,
  input  logic       in_mode_down,
  input  logic       in_adjust,
  input  logic       in_select,
  output logic [7:0] out_seg,
  output logic [3:0] out_an,
  output logic       out_running,
  output logic       out_expired,
  output logic       out_lap
);

  localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int AW = (ADJ_DIV   > 1) ? $clog2(ADJ_DIV)   : 1;
  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [7:0] MM_BCD  = 8'(((MIN_MAX / 10) << 4) | (MIN_MAX % 10));
  localparam logic [7:0] SEC_MAX = 8'h59;

  typedef enum logic [1:0] {ST_STOPPED, ST_RUNNING, ST_EXPIRED} state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_min, r_sec, w_min_nxt, w_sec_nxt;
  logic [TW-1:0]   r_tick_cnt, w_tick_nxt;
  logic [AW-1:0]   r_adj_cnt, w_adj_nxt;
  logic [SW-1:0]   r_scan_cnt;
  logic [BW-1:0]   r_blink_cnt;
  logic [1:0]      r_scan_idx;
  logic            r_blink;
  logic            r_lap, w_lap_nxt;
  logic [15:0]     r_lap_val, w_lapv_nxt;
  logic            r_expired;
  logic [7:0]      r_seg;
  logic [3:0]      r_an;
  logic            w_tick, w_adj_term, w_blank;
  logic [15:0]     w_disp;
  logic [3:0]      w_digit;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lim);
    if (v == 8'h00) return lim;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  assign w_tick     = (r_state == ST_RUNNING) && (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_adj_term = (r_adj_cnt == AW'(ADJ_DIV - 1));

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) r_state <= ST_STOPPED;
    else             r_state <= w_state_nxt;
  end

  // Tick is resolved first so a start_stop on a terminal-count cycle acts on the post-tick state.
  always_comb begin
    w_state_nxt = r_state;
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;
    w_tick_nxt  = r_tick_cnt;
    w_adj_nxt   = '0;
    w_lap_nxt   = r_lap;
    w_lapv_nxt  = r_lap_val;
    if (in_clear) begin
      w_state_nxt = ST_STOPPED;
      w_min_nxt   = 8'h00;
      w_sec_nxt   = 8'h00;
      w_tick_nxt  = '0;
      w_lap_nxt   = 1'b0;
    end else if (in_adjust) begin
      w_state_nxt = ST_STOPPED;
      w_adj_nxt   = w_adj_term ? '0 : r_adj_cnt + AW'(1);
      if (w_adj_term) begin
        if (in_select) w_sec_nxt = bcd_inc(r_sec, SEC_MAX);
        else           w_min_nxt = bcd_inc(r_min, MM_BCD);
      end
    end else begin
      if (r_state == ST_RUNNING) w_tick_nxt = w_tick ? '0 : r_tick_cnt + TW'(1);
      if (w_tick) begin
        if (in_mode_down) begin
          w_sec_nxt = bcd_dec(r_sec, SEC_MAX);
          if (r_sec == 8'h00) w_min_nxt = bcd_dec(r_min, MM_BCD);
          if (w_sec_nxt == 8'h00 && w_min_nxt == 8'h00) w_state_nxt = ST_EXPIRED;
        end else begin
          w_sec_nxt = bcd_inc(r_sec, SEC_MAX);
          if (r_sec == SEC_MAX) w_min_nxt = bcd_inc(r_min, MM_BCD);
        end
      end
      if (in_start_stop) begin
        case (w_state_nxt)
          ST_STOPPED: if (!(in_mode_down && r_min == 8'h00 && r_sec == 8'h00)) w_state_nxt = ST_RUNNING;
          default:    w_state_nxt = ST_STOPPED;
        endcase
      end else if (in_lap && r_state == ST_RUNNING) begin
        w_lap_nxt = !r_lap;
        if (!r_lap) w_lapv_nxt = {r_min, r_sec};
      end
    end
  end

  assign w_disp = r_lap ? r_lap_val : {r_min, r_sec};

  always_comb begin
    w_digit = 4'd0;
    case (r_scan_idx)
      2'd0: w_digit = w_disp[15:12];
      2'd1: w_digit = w_disp[11:8];
      2'd2: w_digit = w_disp[7:4];
      default: w_digit = w_disp[3:0];
    endcase
  end

  // Scan indices 2,3 are the seconds field.
  assign w_blank = !r_blink && ((r_state == ST_EXPIRED) ||
                   (in_adjust && (in_select ? r_scan_idx[1] : !r_scan_idx[1])));

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_min       <= 8'h00;
      r_sec       <= 8'h00;
      r_tick_cnt  <= '0;
      r_adj_cnt   <= '0;
      r_scan_cnt  <= '0;
      r_blink_cnt <= '0;
      r_scan_idx  <= 2'd0;
      r_blink     <= 1'b1;
      r_lap       <= 1'b0;
      r_lap_val   <= 16'h0000;
      r_expired   <= 1'b0;
      r_seg       <= 8'hFF;
      r_an        <= 4'hF;
    end else begin
      r_min      <= w_min_nxt;
      r_sec      <= w_sec_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_adj_cnt  <= w_adj_nxt;
      r_lap      <= w_lap_nxt;
      r_lap_val  <= w_lapv_nxt;
      r_expired  <= (w_state_nxt == ST_EXPIRED) && (r_state != ST_EXPIRED);
      if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
        r_scan_cnt <= '0;
        r_scan_idx <= r_scan_idx + 2'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + SW'(1);
      end
      if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
        r_blink_cnt <= '0;
        r_blink     <= !r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
      r_an  <= ~(4'b1000 >> r_scan_idx);
      r_seg <= w_blank ? 8'hFF : seg_code(w_digit);
    end
  end

  assign out_seg     = r_seg;
  assign out_an      = r_an;
  assign out_running = (r_state == ST_RUNNING);
  assign out_expired = r_expired;
  assign out_lap     = r_lap;

endmodule
